fetch_sequencer: RTL and testbench

//  Owns the fetch-side PC/NPC pair and sequences instruction fetch for the pipelined CPU.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_sequencer_fsm.sv | 53 +++++
 rtl/fetch_sequencer.sv | 83 ++++++++
 tb/tb_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned FETCH_WIDTH    = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'h0000_0004;

endpackage

// File: rtl/fetch_sequencer_fsm.sv
// Fetch control FSM: BOOT -> FETCH, parks in HOLD when an ack lands during a stall.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hazard_stall,
  input  logic   imem_ack,
  output state_e state,
  output logic   imem_req,
  output logic   le_ifid,
  output logic   ibuf_load
);

  state_e state_d;

  // Next-state, advance pulse and buffer-capture decode.
  always_comb begin
    state_d   = state;
    le_ifid   = 1'b0;
    ibuf_load = 1'b0;
    unique case (state)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack && !hazard_stall) begin
          le_ifid = 1'b1;
        end else if (imem_ack && hazard_stall) begin
          ibuf_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!hazard_stall) begin
          le_ifid = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State register; imem_req is registered from the next state so it drops with reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      imem_req <= 1'b0;
    end else begin
      state    <= state_d;
      imem_req <= (state_d == FETCH);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer top: PC/NPC pair, instruction buffer and delayed-branch redirect.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = FETCH_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC),
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(FETCH_PC_STEP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             le_ifid,
  output logic [WIDTH-1:0] instr_out,
  output logic             redir_pend
);

  state_e           state;
  logic             ibuf_load;
  logic [WIDTH-1:0] pc_q, npc_q, ibuf_q, tgt_q;
  logic             pend_q;
  logic             redir_eff;
  logic [WIDTH-1:0] redir_tgt, pc_d;

  fetch_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .imem_ack     (imem_ack),
    .state        (state),
    .imem_req     (imem_req),
    .le_ifid      (le_ifid),
    .ibuf_load    (ibuf_load)
  );

  // Redirect selection: a latched target beats a later br_taken (first target wins).
  always_comb begin
    redir_eff = br_taken | pend_q;
    redir_tgt = pend_q ? tgt_q : br_target;
    pc_d      = redir_eff ? redir_tgt : npc_q;
  end

  // PC/NPC, instruction buffer and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      npc_q  <= RESET_PC + PC_STEP;
      ibuf_q <= '0;
      tgt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (ibuf_load) begin
        ibuf_q <= imem_rdata;
      end
      if (le_ifid) begin
        // The advance that loads the delay slot is the one that moves pc to the target.
        pc_q   <= pc_d;
        npc_q  <= pc_d + PC_STEP;
        pend_q <= 1'b0;
      end else if (br_taken && !pend_q) begin
        tgt_q  <= br_target;
        pend_q <= 1'b1;
      end
    end
  end

  // Outputs: live IMEM data on the ack path, buffered word otherwise.
  always_comb begin
    pc         = pc_q;
    npc        = npc_q;
    imem_addr  = pc_q;
    redir_pend = pend_q;
    instr_out  = (state == FETCH && imem_ack) ? imem_rdata : ibuf_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle model plus directed literal checks.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        le_ifid;
  logic [31:0] instr_out;
  logic        redir_pend;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .npc          (npc),
    .le_ifid      (le_ifid),
    .instr_out    (instr_out),
    .redir_pend   (redir_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: booting / holding a buffered word / fetching; pending redirect.
  bit          m_boot = 1'b1;
  bit          m_held = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_buf  = 32'h0;
  logic [31:0] m_tgt  = 32'h0;

  function automatic bit m_le();
    if (m_boot) return 1'b0;
    if (m_held) return !hazard_stall;
    return imem_ack && !hazard_stall;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit          n_boot, n_held, n_pend;
    logic [31:0] n_pc, n_buf, n_tgt;
    if (!reset) begin
      m_boot <= 1'b1; m_held <= 1'b0; m_pend <= 1'b0;
      m_pc <= 32'h0; m_buf <= 32'h0; m_tgt <= 32'h0;
    end else begin
      n_boot = 1'b0; n_held = m_held; n_pend = m_pend;
      n_pc = m_pc; n_buf = m_buf; n_tgt = m_tgt;
      if (m_le()) begin
        n_pc   = m_pend ? m_tgt : (br_taken ? br_target : m_pc + 32'd4);
        n_pend = 1'b0;
        n_held = 1'b0;
      end else if (br_taken && !m_pend) begin
        n_pend = 1'b1;
        n_tgt  = br_target;
      end
      if (!m_boot && !m_held && imem_ack && hazard_stall) begin
        n_held = 1'b1;
        n_buf  = imem_rdata;
      end
      m_boot <= n_boot; m_held <= n_held; m_pend <= n_pend;
      m_pc <= n_pc; m_buf <= n_buf; m_tgt <= n_tgt;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] exp_instr;
    exp_instr = (!m_boot && !m_held && imem_ack) ? imem_rdata : m_buf;
    check("m_req", imem_req, !(m_boot || m_held));
    check("m_le", le_ifid, m_le());
    check("m_pc", pc, m_pc);
    check("m_addr", imem_addr, m_pc);
    check("m_npc", npc, m_pc + 32'd4);
    check("m_redir", redir_pend, m_pend);
    if (le_ifid || m_held || m_boot) check("m_instr", instr_out, exp_instr);
  end

  task automatic drive(input bit s, input bit a, input bit b, input logic [31:0] t);
    hazard_stall = s;
    imem_ack     = a;
    br_taken     = b;
    br_target    = t;
    imem_rdata   = $urandom;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_npc"}, npc, 32'h4);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_le"}, le_ifid, 1'b0);
    check({tag, "_instr"}, instr_out, 32'h0);
    check({tag, "_redir"}, redir_pend, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;

    // 1: BOOT cycle then one advance per cycle.
    drive(0, 1, 0, 0);
    check("t1_boot_le", le_ifid, 1'b0);
    check("t1_boot_req", imem_req, 1'b0);
    tick();
    drive(0, 1, 0, 0);
    check("t1_le0", le_ifid, 1'b1);
    check("t1_pc0", pc, 32'h0);
    tick();
    drive(0, 1, 0, 0);
    check("t1_pc4", pc, 32'h4);
    tick();
    // 2: ack delayed 3 cycles at pc=8.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      check("t2_req", imem_req, 1'b1);
      check("t2_le", le_ifid, 1'b0);
      check("t2_pc", pc, 32'h8);
      tick();
    end
    drive(0, 1, 0, 0);
    check("t2_le_ack", le_ifid, 1'b1);
    tick();
    check("t1_pcC", pc, 32'hC);
    check("t1_npc10", npc, 32'h10);
    drive(0, 1, 0, 0);
    tick();
    // 3: ack at 0x10 under a 2-cycle stall.
    check("t3_pc", pc, 32'h10);
    drive(1, 1, 0, 0);
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t3_le_stall", le_ifid, 1'b0);
    tick();
    drive(1, 0, 0, 0);
    check("t3_hold_req", imem_req, 1'b0);
    check("t3_hold_instr", instr_out, 32'hDEAD_BEEF);
    check("t3_hold_le", le_ifid, 1'b0);
    tick();
    drive(0, 0, 0, 0);
    check("t3_rel_le", le_ifid, 1'b1);
    check("t3_rel_instr", instr_out, 32'hDEAD_BEEF);
    tick();
    check("t3_pc14", pc, 32'h14);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    // 4: taken branch as the delay slot at 0x24 advances.
    check("t4_pc24", pc, 32'h24);
    drive(0, 1, 1, 32'h100);
    check("t4_le", le_ifid, 1'b1);
    tick();
    check("t4_pc", pc, 32'h100);
    check("t4_npc", npc, 32'h104);
    // 5: two branches while waiting for ack; first target wins.
    drive(0, 0, 1, 32'h200);
    tick();
    check("t5_pend1", redir_pend, 1'b1);
    drive(0, 0, 1, 32'h300);
    tick();
    check("t5_pend2", redir_pend, 1'b1);
    drive(0, 1, 0, 0);
    tick();
    check("t5_pc", pc, 32'h200);
    check("t5_pend0", redir_pend, 1'b0);
    // 6: wrap at the top of the address space, then reset mid-HOLD.
    drive(0, 1, 1, 32'hFFFF_FFFC);
    tick();
    check("t6_pcFC", pc, 32'hFFFF_FFFC);
    check("t6_npc0", npc, 32'h0);
    drive(0, 1, 0, 0);
    tick();
    check("t6_wrap_pc", pc, 32'h0);
    check("t6_wrap_npc", npc, 32'h4);
    drive(1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    check("t6_in_hold", imem_req, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    tick();
    reset = 1'b1;
    // Branch during BOOT is held pending and applied on the first advance.
    drive(0, 1, 1, 32'h40);
    tick();
    check("boot_pend", redir_pend, 1'b1);
    check("boot_pc", pc, 32'h0);
    drive(0, 1, 0, 0);
    check("boot_le", le_ifid, 1'b1);
    tick();
    check("boot_pc40", pc, 32'h40);
    check("boot_npc44", npc, 32'h44);
    check("boot_pend0", redir_pend, 1'b0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
